decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-004 SHALL have instr  input  32  RV32 instruction, valid when in_valid=1.
REQ-005 SHALL have rs1_addr, rs2_addr  output  5 each  register-file read addresses, combinational from instr[19:15], instr[24:20].
REQ-006 SHALL have rs1_data, rs2_data  input  32 each  register-file read data, same cycle as instr.
REQ-007 SHALL have flush  input  1  discard all held and incoming instructions.
REQ-008 SHALL have out_valid / out_ready  output / input  1 / 1  ALU-side handshake.
REQ-009 SHALL have rs1, rs2  output  32 each; alu_op  output  5; alu_en  output  1; imm_alu  output  12; rd  output  5; illegal  output  1; all ALU-facing.

Function
REQ-010 SHALL transfer an instruction on any edge with in_valid & in_ready; outputs appear on the next cycle (1-cycle latency).
REQ-011 SHALL consume an output on any edge with out_valid & out_ready.
REQ-012 SHALL hold a main register plus one skid register; in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-013 SHALL, when out_ready=0 and main is full, capture the accepted instruction in skid; on the next drain, skid moves to main.
REQ-014 SHALL hold all ALU-facing outputs stable while out_valid=1 and out_ready=0.
REQ-015 SHALL, when accept and consume occur on the same edge with skid empty, load main directly (full throughput, no bubble).
REQ-016 SHALL force rs1/rs2 to 0 when the matching address is 0, regardless of rs*_data.
REQ-017 SHALL, for opcode 0110011, decode: funct7=0000000 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3; funct7=0100000 -> SUB (f3=000), SRA (f3=101); funct7=0000001 -> MUL (f3=000), DIV (f3=100).
REQ-018 SHALL, for opcode 0010011, decode ADDI/SLTI/XORI/ORI/ANDI by funct3; SLLI (f3=001, f7=0000000); SRLI/SRAI (f3=101, f7=0000000/0100000).
REQ-019 SHALL set imm_alu = instr[31:20] for non-shift I-type, {7'b0, instr[24:20]} for SLLI/SRLI/SRAI, and 0 for R-type.
REQ-020 SHALL treat any other encoding, including SLTIU, as illegal: alu_op=NOP, alu_en=0, illegal=1, rd=0, with the instruction still passing the handshake.
REQ-021 SHALL set alu_en=1 with each out_valid of a legal instruction, and set alu_en=0 whenever out_valid=0.
REQ-022 SHALL, on flush, invalidate main and skid at the next edge, drop any same-edge incoming instruction, and set in_ready=1 the cycle after.
REQ-023 SHALL give flush priority over both accept and consume on the same edge.

Reset
REQ-024 SHALL, while rst=0, force out_valid=0, in_ready=0, alu_en=0, illegal=0, alu_op=NOP, rs1=rs2=0, imm_alu=0, rd=0, and empty both registers.
REQ-025 SHALL raise in_ready on the first edge after rst deasserts.
REQ-026 SHALL discard any in-flight instruction when reset is asserted mid-operation, with no partial output.

Structure
REQ-027 SHALL take alu_op codes from shared package riscv_pkg: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, ADDI=10, ANDI=11, ORI=12, XORI=13, SLLI=14, SRLI=15, SRAI=16, MUL=17, DIV=18, SLTI=19, NOP=31.
REQ-028 SHALL also place the opcode constants (OP=0110011, OP_IMM=0010011) and a decoded-entry struct {rs1, rs2, alu_op, imm, rd, illegal} in riscv_pkg.
REQ-029 SHALL use one combinational sub-module, instr_decoder (instr -> decoded fields), with the skid/handshake logic in decode_stage.

Verification
REQ-030 SHALL cover: in 0x00208033 (add x0,x1,x2) with x1=5, x2=7 -> next cycle out_valid=1, alu_op=ADD, rs1=5, rs2=7, rd=0.
REQ-031 SHALL cover: in 0x40315093 (srai x1,x2,3) -> alu_op=SRAI, imm_alu=0x003, rd=1; and 0xFFF00093 (addi x1,x0,-1) -> ADDI, imm_alu=0xFFF, rs1=0 with rs1_data=0xDEADBEEF.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with back-to-back inputs -> exactly 2 accepted, in_ready=0 on the 3rd, outputs stable; release -> both delivered in order with no loss or duplication.
REQ-033 SHALL cover: 0x0000307F (illegal opcode) -> out_valid=1, illegal=1, alu_en=0, alu_op=31.
REQ-034 SHALL cover: flush with main+skid full and in_valid=1 -> next cycle out_valid=0, following cycle in_ready=1, with no stale output afterwards.
REQ-035 SHALL cover: rst pulled low mid-stall -> all outputs at reset values immediately (asynchronous), and in_ready=1 one edge after release.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg: ALU op codes, opcode constants and decoded-entry type shared by
//            the decode stage and its instruction decoder.
// Revision: 1.0
// ============================================================================
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_ADDI = 5'd10,
    ALU_ANDI = 5'd11,
    ALU_ORI  = 5'd12,
    ALU_XORI = 5'd13,
    ALU_SLLI = 5'd14,
    ALU_SRLI = 5'd15,
    ALU_SRAI = 5'd16,
    ALU_MUL  = 5'd17,
    ALU_DIV  = 5'd18,
    ALU_SLTI = 5'd19,
    ALU_NOP  = 5'd31
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    alu_op_e     alu_op;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic        illegal;
  } dec_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// instr_decoder: combinational decode of one RV32 OP / OP-IMM instruction
//                into ALU op, immediate, destination and operand values.
// Revision: 1.0
// ============================================================================
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output dec_entry_t  o_dec
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rs1_addr;
  logic [4:0] w_rs2_addr;
  alu_op_e    w_op;
  logic       w_legal;
  logic       w_shift;

  assign w_opc      = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  assign w_rs1_addr = i_instr[19:15];
  assign w_rs2_addr = i_instr[24:20];

  always_comb begin
    w_op    = ALU_NOP;
    w_legal = 1'b0;
    w_shift = 1'b0;
    case (w_opc)
      OPC_OP: begin
        case (w_f7)
          F7_BASE: begin
            w_legal = 1'b1;
            case (w_f3)
              3'b000:  w_op = ALU_ADD;
              3'b001:  w_op = ALU_SLL;
              3'b010:  w_op = ALU_SLT;
              3'b011:  w_op = ALU_SLTU;
              3'b100:  w_op = ALU_XOR;
              3'b101:  w_op = ALU_SRL;
              3'b110:  w_op = ALU_OR;
              default: w_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (w_f3 == 3'b000) begin
              w_op    = ALU_SUB;
              w_legal = 1'b1;
            end else if (w_f3 == 3'b101) begin
              w_op    = ALU_SRA;
              w_legal = 1'b1;
            end
          end
          F7_MULDIV: begin
            if (w_f3 == 3'b000) begin
              w_op    = ALU_MUL;
              w_legal = 1'b1;
            end else if (w_f3 == 3'b100) begin
              w_op    = ALU_DIV;
              w_legal = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        case (w_f3)
          3'b000: begin w_op = ALU_ADDI; w_legal = 1'b1; end
          3'b010: begin w_op = ALU_SLTI; w_legal = 1'b1; end
          3'b100: begin w_op = ALU_XORI; w_legal = 1'b1; end
          3'b110: begin w_op = ALU_ORI;  w_legal = 1'b1; end
          3'b111: begin w_op = ALU_ANDI; w_legal = 1'b1; end
          3'b001: begin
            w_shift = 1'b1;
            if (w_f7 == F7_BASE) begin
              w_op    = ALU_SLLI;
              w_legal = 1'b1;
            end
          end
          3'b101: begin
            w_shift = 1'b1;
            if (w_f7 == F7_BASE) begin
              w_op    = ALU_SRLI;
              w_legal = 1'b1;
            end else if (w_f7 == F7_ALT) begin
              w_op    = ALU_SRAI;
              w_legal = 1'b1;
            end
          end
          default: ; // SLTIU is deliberately unsupported
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    o_dec         = '0;
    o_dec.rs1     = (w_rs1_addr == 5'd0) ? 32'd0 : i_rs1_data;
    o_dec.rs2     = (w_rs2_addr == 5'd0) ? 32'd0 : i_rs2_data;
    o_dec.alu_op  = w_legal ? w_op : ALU_NOP;
    o_dec.rd      = w_legal ? i_instr[11:7] : 5'd0;
    o_dec.illegal = ~w_legal;
    if (w_legal && (w_opc == OPC_OP_IMM)) begin
      o_dec.imm = w_shift ? {7'd0, i_instr[24:20]} : i_instr[31:20];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage: RV32 decode pipeline stage with main + skid register,
//               registered in_ready and flush handling.
// Revision: 1.0
// ============================================================================
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [4:0]  alu_op,
  output logic        alu_en,
  output logic [11:0] imm_alu,
  output logic [4:0]  rd,
  output logic        illegal
);

  dec_entry_t w_dec;
  dec_entry_t r_main;
  dec_entry_t r_skid;
  dec_entry_t w_main_nxt;
  dec_entry_t w_skid_nxt;
  logic       r_main_vld;
  logic       r_skid_vld;
  logic       r_in_ready;
  logic       w_main_vld_nxt;
  logic       w_skid_vld_nxt;
  logic       w_accept;
  logic       w_consume;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  instr_decoder u_dec (
    .i_instr    (instr),
    .i_rs1_data (rs1_data),
    .i_rs2_data (rs2_data),
    .o_dec      (w_dec)
  );

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_main_vld & out_ready;

  // Skid is only ever occupied while main is occupied, and in_ready low
  // guarantees no accept can coincide with a full skid.
  always_comb begin
    w_main_nxt     = r_main;
    w_skid_nxt     = r_skid;
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    if (flush) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (!r_main_vld || w_consume) begin
      if (r_skid_vld) begin
        w_main_nxt     = r_skid;
        w_main_vld_nxt = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end else begin
        w_main_nxt     = w_dec;
        w_main_vld_nxt = w_accept;
      end
    end else if (w_accept) begin
      w_skid_nxt     = w_dec;
      w_skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_in_ready <= ~w_skid_vld_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_vld;
  assign alu_en    = r_main_vld & ~r_main.illegal;
  assign illegal   = r_main_vld & r_main.illegal;
  assign alu_op    = r_main_vld ? r_main.alu_op : ALU_NOP;
  assign rs1       = r_main_vld ? r_main.rs1 : 32'd0;
  assign rs2       = r_main_vld ? r_main.rs2 : 32'd0;
  assign imm_alu   = r_main_vld ? r_main.imm : 12'd0;
  assign rd        = r_main_vld ? r_main.rd : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage: directed + randomized bench for decode_stage against a
//                  queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  alu_op;
  logic        alu_en;
  logic [11:0] imm_alu;
  logic [4:0]  rd;
  logic        illegal;

  int n_cmp = 0;
  int n_fail = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2),
    .alu_op(alu_op), .alu_en(alu_en), .imm_alu(imm_alu), .rd(rd),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [4:0]  rd;
    bit          ill;
  } exp_t;

  exp_t m_q[$];
  bit   m_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference decode straight from the ISA tables.
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] d1, logic [31:0] d2);
    exp_t e;
    int   r_tab[8];
    int   i_tab[8];
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    r_tab = '{0, 5, 8, 9, 4, 6, 3, 2};
    i_tab = '{10, 14, 19, 31, 13, 15, 12, 11};
    opc = ins[6:0];
    f7  = ins[31:25];
    f3  = ins[14:12];
    e.op  = 31;
    e.imm = 12'd0;
    e.rd  = 5'd0;
    e.ill = 1'b1;
    e.a   = (ins[19:15] == 5'd0) ? 32'd0 : d1;
    e.b   = (ins[24:20] == 5'd0) ? 32'd0 : d2;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) e.op = r_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.op = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) e.op = 7;
      else if (f7 == 7'h01 && f3 == 3'd0) e.op = 17;
      else if (f7 == 7'h01 && f3 == 3'd4) e.op = 18;
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = {7'd0, ins[24:20]};
        if (f7 == 7'h00) e.op = i_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 16;
      end else begin
        e.imm = ins[31:20];
        e.op  = i_tab[f3];
      end
    end
    if (e.op != 31) begin
      e.ill = 1'b0;
      e.rd  = ins[11:7];
    end else begin
      e.imm = 12'd0;
    end
    return e;
  endfunction

  // Model: an ordered queue of at most two held instructions.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_rdy = 1'b0;
    end else begin
      if (flush) begin
        m_q.delete();
      end else begin
        if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (in_valid && m_rdy) m_q.push_back(ref_decode(instr, rs1_data, rs2_data));
      end
      m_rdy = (m_q.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
    if (!rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd31);
      chk("rst_alu_en", 32'(alu_en), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("alu_op", 32'(alu_op), 32'(m_q[0].op));
        chk("illegal", 32'(illegal), 32'(m_q[0].ill));
        chk("alu_en", 32'(alu_en), 32'(!m_q[0].ill));
        chk("rd", 32'(rd), 32'(m_q[0].rd));
        if (!m_q[0].ill) begin
          chk("rs1", rs1, m_q[0].a);
          chk("rs2", rs2, m_q[0].b);
          chk("imm_alu", 32'(imm_alu), 32'(m_q[0].imm));
        end
      end else begin
        chk("idle_alu_en", 32'(alu_en), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    ins = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    ins[6:0] = 7'h33;
      2:       ins[6:0] = 7'h13;
      default: ins[6:0] = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    ins[31:25] = f7;
    if ($urandom_range(0, 7) == 0) ins[19:15] = 5'd0;
    if ($urandom_range(0, 7) == 0) ins[24:20] = 5'd0;
    return ins;
  endfunction

  initial begin
    exp_t e;
    // Pin the reference decoder with hand-decoded encodings.
    e = ref_decode(32'h40315093, 32'd0, 32'd0);
    chk("model_srai_op", 32'(e.op), 32'd16);
    chk("model_srai_imm", 32'(e.imm), 32'h003);
    e = ref_decode(32'h0000307F, 32'd0, 32'd0);
    chk("model_illegal_op", 32'(e.op), 32'd31);
    e = ref_decode(32'h00003013, 32'd0, 32'd0);
    chk("model_sltiu_ill", 32'(e.ill), 32'd1);

    repeat (3) tick();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // add x0,x1,x2
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'h00208033; rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(alu_op), 32'd0);
    chk("add_rs1", rs1, 32'd5);
    chk("add_rs2", rs2, 32'd7);
    chk("add_rd", 32'(rd), 32'd0);
    // srai x1,x2,3
    instr = 32'h40315093; rs1_data = 32'h11;
    tick();
    chk("srai_op", 32'(alu_op), 32'd16);
    chk("srai_imm", 32'(imm_alu), 32'h003);
    chk("srai_rd", 32'(rd), 32'd1);
    // addi x1,x0,-1 with garbage on rs1_data
    instr = 32'hFFF00093; rs1_data = 32'hDEADBEEF;
    tick();
    chk("addi_op", 32'(alu_op), 32'd10);
    chk("addi_imm", 32'(imm_alu), 32'hFFF);
    chk("addi_rs1_zero", rs1, 32'd0);
    // illegal opcode
    instr = 32'h0000307F;
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_alu_en", 32'(alu_en), 32'd0);
    chk("ill_op", 32'(alu_op), 32'd31);
    in_valid = 1'b0;
    tick();

    // Stall: three back-to-back offers, only two fit.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr = 32'h00208233;
    tick();
    instr = 32'h002082B3;
    tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_rd_stable", 32'(rd), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("drain_second", 32'(rd), 32'd4);
    tick();
    chk("drain_third", 32'(rd), 32'd5);
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Flush with both registers full and an incoming instruction.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr = 32'h00208233;
    tick();
    flush = 1'b1; instr = 32'h002082B3;
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_no_stale", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr = 32'h00208233;
    tick();
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_alu_op", 32'(alu_op), 32'd31);
    chk("arst_rs1", rs1, 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_release_rdy", 32'(in_ready), 32'd1);
    chk("arst_release_vld", 32'(out_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      instr     = rand_instr();
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
